// File: rtl/fish_motion_ctrl.sv
// Per-frame fish sprite motion controller: spawns at the right edge on a pseudo-random row,
// moves left once per frame, respawns after a delay. Optional macro: FISH_WOBBLE_EN.
module fish_motion_ctrl #(
    parameter int          H_ACTIVE       = 640,
    parameter int          V_ACTIVE       = 480,
    parameter int          FISH_H         = 5,
    parameter int          RESPAWN_FRAMES = 30,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter logic        VSYNC_ACTIVE   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       run,
    input  logic [2:0] speed,
    output logic [9:0] fish_x,
    output logic [9:0] fish_y,
    output logic       fish_valid,
    output logic [7:0] lap_count,
    output logic       frame_tick
);

`ifdef FISH_WOBBLE_EN
    localparam int ROW_LIM = V_ACTIVE - FISH_H - 2;
`else
    localparam int ROW_LIM = V_ACTIVE - FISH_H;
`endif
    localparam logic [9:0] X_SPAWN = 10'(H_ACTIVE);
    localparam logic [9:0] Y_LIM   = 10'(ROW_LIM);
    localparam int         WCW     = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(RESPAWN_FRAMES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SPAWN, ST_SWIM, ST_WAIT} state_t;

    state_t         state_q, state_d;
    logic           vs_d1, vs_d2;
    logic [15:0]    lfsr_q, lfsr_d, lfsr_next;
    logic [9:0]     base_y_q, base_y_d, x_d, row_y, row_raw;
    logic           valid_d;
    logic [7:0]     lap_d;
    logic [WCW-1:0] wait_q, wait_d;
    logic [2:0]     spd;
    logic           step;

    // Two-stage vsync sampling; the tick fires on the inactive-to-active transition only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d1      <= ~VSYNC_ACTIVE;
            vs_d2      <= ~VSYNC_ACTIVE;
            frame_tick <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            vs_d1      <= vsync;
            vs_d2      <= vs_d1;
            frame_tick <= (vs_d1 == VSYNC_ACTIVE) && (vs_d2 != VSYNC_ACTIVE);
        end
    end

    assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign row_raw   = {1'b0, lfsr_next[8:0]};
    // One conditional subtract folds the 9-bit value into range without a divider.
    assign row_y     = (row_raw >= Y_LIM) ? (row_raw - Y_LIM) : row_raw;
    assign spd       = (speed == 3'd0) ? 3'd1 : speed;
    assign step      = frame_tick && run;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        state_d  = state_q;
        x_d      = fish_x;
        base_y_d = base_y_q;
        valid_d  = fish_valid;
        lap_d    = lap_count;
        wait_d   = wait_q;
        lfsr_d   = lfsr_q;
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (step) state_d = ST_SPAWN;
            end
            ST_SPAWN: begin
                lfsr_d   = lfsr_next;
                base_y_d = row_y;
                x_d      = X_SPAWN;
                valid_d  = 1'b1;
                state_d  = ST_SWIM;
            end
            ST_SWIM: begin
                if (step) begin
                    if (fish_x > {7'd0, spd}) begin
                        x_d = fish_x - {7'd0, spd};
                    end else begin
                        valid_d = 1'b0;
                        if (lap_count != 8'hFF) lap_d = lap_count + 8'd1;
                        wait_d  = '0;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (step) begin
                    if (wait_q == WAIT_LAST) state_d = ST_SPAWN;
                    else                     wait_d  = wait_q + WCW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fish_x     <= X_SPAWN;
            base_y_q   <= '0;
            fish_valid <= 1'b0;
            lap_count  <= '0;
            wait_q     <= '0;
            lfsr_q     <= LFSR_SEED;
        end else begin
            state_q    <= state_d;
            fish_x     <= x_d;
            base_y_q   <= base_y_d;
            fish_valid <= valid_d;
            lap_count  <= lap_d;
            wait_q     <= wait_d;
            lfsr_q     <= lfsr_d;
        end
    end

`ifdef FISH_WOBBLE_EN
    logic [3:0] fcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          fcnt_q <= '0;
        else if (frame_tick) fcnt_q <= fcnt_q + 4'd1;
    end

    assign fish_y = base_y_q + {8'd0, fcnt_q[3], 1'b0};
`else
    assign fish_y = base_y_q;
`endif

endmodule

// File: tb/tb_fish_motion_ctrl.sv
// Self-checking bench for fish_motion_ctrl (default build, FISH_WOBBLE_EN undefined).
module tb_fish_motion_ctrl;

    localparam logic ACT = 1'b0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync = ~ACT;
    logic       run = 1'b0;
    logic [2:0] speed = 3'd0;
    logic [9:0] fish_x, fish_y;
    logic       fish_valid, frame_tick;
    logic [7:0] lap_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       run;
        logic [2:0] speed;
        logic [9:0] x;
        logic [9:0] y;
        logic       valid;
        logic [7:0] lap;
    } vec_t;

    vec_t sb[$];

    fish_motion_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync      (vsync),
        .run        (run),
        .speed      (speed),
        .fish_x     (fish_x),
        .fish_y     (fish_y),
        .fish_valid (fish_valid),
        .lap_count  (lap_count),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: act=%0d req=%0d", name, act, req);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [9:0] row_of(input logic [15:0] l);
        logic [9:0] r;
        r = {1'b0, l[8:0]};
        return (r >= 10'd475) ? r - 10'd475 : r;
    endfunction

    function automatic vec_t mk(input logic r, input logic [2:0] s, input int x, input int y,
                                input logic v, input int lap);
        vec_t e;
        e.run = r; e.speed = s; e.x = 10'(x); e.y = 10'(y); e.valid = v; e.lap = 8'(lap);
        return e;
    endfunction

    task automatic compare_sb(input string tag);
        vec_t e;
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s: act=empty_queue req=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, ".x"},     fish_x,     e.x);
            check({tag, ".y"},     fish_y,     e.y);
            check({tag, ".valid"}, fish_valid, e.valid);
            check({tag, ".lap"},   lap_count,  e.lap);
        end
    endtask

    // One vsync frame; the expected outputs after the frame are queued before driving it.
    task automatic do_frame(input string tag, input vec_t e);
        sb.push_back(e);
        @(negedge clk);
        run = e.run; speed = e.speed; vsync = ACT;
        repeat (4) @(negedge clk);
        vsync = ~ACT;
        repeat (4) @(negedge clk);
        compare_sb(tag);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".x"},    fish_x,     640);
        check({tag, ".y"},    fish_y,     0);
        check({tag, ".valid"}, fish_valid, 0);
        check({tag, ".lap"},  lap_count,  0);
        check({tag, ".tick"}, frame_tick, 0);
    endtask

    vec_t vecs[8];

    initial begin
        logic [15:0] l1, l2;
        int lat, pulses;
        logic [9:0] y1, y2;

        l1 = lfsr_step(16'hACE1);
        l2 = lfsr_step(l1);
        y1 = row_of(l1);
        y2 = row_of(l2);

        vecs[0] = mk(1, 3'd3, 640, 451, 1, 0);
        vecs[1] = mk(1, 3'd3, 637, 451, 1, 0);
        vecs[2] = mk(1, 3'd3, 634, 451, 1, 0);
        vecs[3] = mk(1, 3'd3, 631, 451, 1, 0);
        vecs[4] = mk(1, 3'd3, 628, 451, 1, 0);
        vecs[5] = mk(1, 3'd3, 625, 451, 1, 0);
        vecs[6] = mk(1, 3'd0, 624, 451, 1, 0);
        vecs[7] = mk(0, 3'd5, 624, 451, 1, 0);

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Tick latency and single pulse while idle.
        vsync = ACT;
        lat = 0;
        pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (frame_tick) begin
                if (pulses == 0) lat = i;
                pulses++;
            end
        end
        check("tick_latency", lat, 2);
        check("tick_pulses", pulses, 1);
        @(negedge clk); vsync = ~ACT;
        repeat (4) @(negedge clk);
        check("idle_valid", fish_valid, 0);
        check("spawn_row_model", y1, 451);

        for (int i = 0; i < 8; i++) do_frame($sformatf("vec%0d", i), vecs[i]);

        for (int i = 0; i < 10; i++) do_frame($sformatf("freeze%0d", i), mk(0, 3'd7, 624, 451, 1, 0));

        // run drops in the cycle the tick is high: tick ignored.
        sb.push_back(mk(1, 3'd3, 624, 451, 1, 0));
        @(negedge clk); run = 1'b1; speed = 3'd3; vsync = ACT;
        repeat (2) @(negedge clk);
        check("runfall_tick", frame_tick, 1);
        run = 1'b0;
        repeat (6) @(negedge clk);
        vsync = ~ACT;
        repeat (4) @(negedge clk);
        compare_sb("runfall");

        for (int i = 1; i <= 32; i++)
            do_frame($sformatf("to400_%0d", i), mk(1, 3'd7, 624 - 7 * i, 451, 1, 0));

        // Asynchronous reset mid-SWIM.
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_frame("respawn", mk(1, 3'd7, 640, 451, 1, 0));
        for (int i = 1; i <= 91; i++)
            do_frame($sformatf("swim%0d", i), mk(1, 3'd7, 640 - 7 * i, 451, 1, 0));
        do_frame("exit", mk(1, 3'd7, 3, 451, 0, 1));

        for (int i = 0; i < 5; i++) do_frame($sformatf("waitfrz%0d", i), mk(0, 3'd7, 3, 451, 0, 1));
        for (int i = 1; i < 30; i++) do_frame($sformatf("wait%0d", i), mk(1, 3'd7, 3, 451, 0, 1));
        do_frame("spawn2", mk(1, 3'd7, 640, int'(y2), 1, 1));
        do_frame("spawn2_move", mk(1, 3'd0, 639, int'(y2), 1, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
